window_gen_3x3: RTL and testbench
=================================

Name: window_gen_3x3

Overview:
- Producer end of the 3x3 pixel-window interface consumed by the filter's first pipeline stage (p1..p9, p5 = centre).
- Accepts a raster-order 8-bit pixel stream.
- Buffers two previous image rows internally.
- Emits a registered, valid-qualified 3x3 window for every interior centre pixel, plus an end-of-frame pulse.

Parameters:
- IMG_W, 64, pixels per row (>= 3)
- IMG_H, 64, rows per frame (>= 3)
- PIX_W, 8, pixel width in bits

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- act  in  1  enable; 0 = stall, all state holds
- pix_valid  in  1  pix_in carries a pixel this cycle
- pix_sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0)
- pix_in  in  PIX_W  pixel data
- p1..p9  out  PIX_W each  window, row-major; p1 = (r-2,c-2), p5 = (r-1,c-1), p9 = (r,c)
- win_valid  out  1  p1..p9 hold a new interior window this cycle
- frame_done  out  1  one-cycle pulse alongside the last window of a frame

Behaviour:
- Interface contract: one clock domain; reset is synchronous and active-high, port names clk and rst.
- Reset: p1..p9 = 0, win_valid = 0, frame_done = 0, row/col counters = 0.
  - Line-buffer contents are not cleared.
  - Stale line-buffer data is never exposed, because of the row >= 2 gating below.
- Accept condition: accept = pix_valid & act & ~rst.
  - With act = 0 or pix_valid = 0, nothing is accepted.
  - Counters, line buffers and window registers all hold.
  - win_valid and frame_done are 0 on the following cycle.
- Counters: col 0..IMG_W-1, row 0..IMG_H-1; width $clog2 of each bound.
  - On accept, col increments; at IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0. The next frame may start without pix_sof.
- pix_sof on an accepted pixel: that pixel is treated as (0,0) regardless of counter state. This includes mid-frame, which abandons the partial frame.
  - Counters then advance to (0,1).
  - No window is emitted for the abandoned frame.
- Line buffers: two chained delay lines, each IMG_W accepted pixels deep.
  - lb0 input = pix_in; its output = pixel (r-1,c).
  - lb1 input = lb0 output; its output = pixel (r-2,c).
  - Each buffer advances only on accept.
- Window registers: on accept, the 3x3 shifts left one column.
  - New right column: p3 <= lb1_out, p6 <= lb0_out, p9 <= pix_in.
  - Remaining shifts: p1 <= p2 <= p3, p4 <= p5 <= p6, p7 <= p8 <= p9.
- win_valid is registered as (accept & row >= 2 & col >= 2).
  - Latency: 1 cycle from accepting pixel (r,c) to the window centred on (r-1,c-1).
  - Windows straddling a row boundary (col < 2) are never flagged valid.
- frame_done is registered as (accept & row == IMG_H-1 & col == IMG_W-1). It always coincides with a win_valid.
- Throughput: 1 window per cycle at full rate; no back-pressure output.
- Reset mid-frame: the same cycle's pixel is discarded; counters restart at (0,0).
- Per frame: exactly (IMG_W-2)*(IMG_H-2) win_valid pulses and one frame_done.

Decomposition:
- Shared package filt_pkg:
  - PIX_W default
  - pixel typedef (logic [PIX_W-1:0])
  - window typedef (array of 9 pixels, index 0 = p1)
- One sub-module: line_buffer.
  - Parameters DEPTH, WIDTH; ports clk, rst, en, din, dout.
  - Behaviour: dout = din delayed by DEPTH enabled cycles; implemented as a circular RAM with a read-before-write pointer.
  - Instantiated twice.

Test Plan (IMG_W = 4, IMG_H = 4, pixel value = 16*r + c, act = 1 unless stated):
- Full-rate frame with pix_sof on the first pixel:
  - First win_valid comes 1 cycle after pixel (2,2): p1..p9 = 00,01,02,10,11,12,20,21,22.
  - Exactly 4 win_valid pulses.
  - The last window has p5 = 22, p9 = 33, with frame_done = 1 on the same cycle.
- Same frame with random pix_valid gaps and act dropped for 3 cycles mid-row 2:
  - No win_valid while stalled; p1..p9 hold.
  - The window sequence is identical to the full-rate case.
- Two back-to-back frames without a second pix_sof:
  - The second frame yields the same 4 windows; frame_done pulses twice.
- rst asserted for 1 cycle after pixel (2,3) is accepted:
  - Next cycle all outputs are 0.
  - The following pixel is treated as (0,0).
  - First win_valid occurs only after the 11th accepted pixel.
- pix_sof asserted mid-frame at original pixel (1,2):
  - No window is emitted from the abandoned frame.
  - The new frame produces windows exactly as in the first test.
- Stall boundary: act = 0 with pix_valid = 1 on the (3,3) pixel, then act = 1 on the next cycle:
  - frame_done and the final window appear only 1 cycle after the actual accept.

Source files
------------

// File: rtl/filt_pkg.sv
// Shared pixel/window types for the filter front end.
// Window index 0 is p1 (top-left), index 8 is p9 (bottom-right, newest pixel).
package filt_pkg;

    localparam int PIX_W_DEF = 8;

    typedef logic [PIX_W_DEF-1:0] pixel_t;
    typedef pixel_t window_t [9];

    function automatic int win_idx(input int r, input int c);
        return r * 3 + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Delay line of DEPTH enabled cycles built on a circular RAM.
// dout is read combinationally at the pointer before the same slot is overwritten.
module line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    // Contents are deliberately left uncleared; the window gating hides stale rows.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers supply rows r-1 and r-2; windows are flagged only for interior centres.
module window_gen_3x3
    import filt_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    output logic [PIX_W-1:0] p9,
    output logic             win_valid,
    output logic             frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]    col, col_eff, col_nxt;
    logic [RW-1:0]    row, row_eff, row_nxt;
    logic             accept, interior, is_last;
    logic [PIX_W-1:0] lb0_out, lb1_out;
    logic [PIX_W-1:0] win [9];

    assign accept = pix_valid & act & ~rst;

    // A start-of-frame pixel is position (0,0) whatever the counters say.
    always_comb begin
        row_eff  = pix_sof ? '0 : row;
        col_eff  = pix_sof ? '0 : col;
        row_nxt  = row_eff;
        col_nxt  = col_eff + 1'b1;
        if (col_eff == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
        end
        interior = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
        is_last  = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
    end

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (pix_in),
        .dout (lb0_out)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            row        <= '0;
            col        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else begin
            win_valid  <= accept & interior;
            frame_done <= accept & is_last;
            if (accept) begin
                row <= row_nxt;
                col <= col_nxt;
                for (int r = 0; r < 3; r++) begin
                    win[win_idx(r, 0)] <= win[win_idx(r, 1)];
                    win[win_idx(r, 1)] <= win[win_idx(r, 2)];
                end
                win[win_idx(0, 2)] <= lb1_out;
                win[win_idx(1, 2)] <= lb0_out;
                win[win_idx(2, 2)] <= pix_in;
            end
        end
    end

    assign p1 = win[0];
    assign p2 = win[1];
    assign p3 = win[2];
    assign p4 = win[3];
    assign p5 = win[4];
    assign p6 = win[5];
    assign p7 = win[6];
    assign p8 = win[7];
    assign p9 = win[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 4x4 image with pixel value 16*r + c.
// An image-array model predicts each window; directed tests pin the model with literals.
module tb_window_gen_3x3;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       act = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_sof = 1'b0;
    logic [7:0] pix_in = '0;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic       win_valid, frame_done;

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .act        (act),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_in     (pix_in),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .p9         (p9),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [71:0] obs;
    assign obs = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pv(input int r, input int c);
        return 8'(16 * r + c);
    endfunction

    // Model: record pixels by image position, read windows straight out of the image.
    logic [7:0]  img [H][W];
    int          mr = 0, mc = 0;
    logic        ev = 1'b0, ed = 1'b0, known = 1'b0;
    logic [71:0] ew = '0;

    always @(posedge clk) begin
        if (rst) begin
            mr = 0; mc = 0; ev = 1'b0; ed = 1'b0; ew = '0; known = 1'b1;
        end else if (pix_valid && act) begin
            if (pix_sof) begin
                mr = 0; mc = 0;
            end
            img[mr][mc] = pix_in;
            ev = (mr >= 2) && (mc >= 2);
            ed = (mr == H - 1) && (mc == W - 1);
            if (ev) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[71 - 8 * (i * 3 + j) -: 8] = img[mr - 2 + i][mc - 2 + j];
                known = 1'b1;
            end else begin
                known = 1'b0;
            end
            mc = mc + 1;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end else begin
            ev = 1'b0;
            ed = 1'b0;
        end
    end

    logic        chk_on = 1'b0;
    logic [71:0] obs_q [$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("win_valid", {71'd0, win_valid}, {71'd0, ev});
            chk("frame_done", {71'd0, frame_done}, {71'd0, ed});
            if (ev || known)
                chk("window", obs, ew);
            if (win_valid)
                obs_q.push_back(obs);
            if (frame_done)
                done_cnt++;
        end
    end

    task automatic step(input logic v, input logic s, input logic a, input logic r, input logic [7:0] d);
        pix_valid = v;
        pix_sof   = s;
        act       = a;
        rst       = r;
        pix_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    // Sends pixels k_from..k_to (raster index) of a frame.
    task automatic send_range(input int k_from, input int k_to, input bit sof_first, input bit gaps, input bit drop);
        for (int k = k_from; k <= k_to; k++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) begin
                    if ($urandom_range(0, 1) == 0)
                        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hee);
                    else
                        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hee);
                end
            end
            if (drop && k == 2 * W + 3) begin
                for (int g = 0; g < 3; g++)
                    step(1'b1, 1'b0, 1'b0, 1'b0, pv(k / W, k % W));
                chk("stall_hold", obs, 72'h000102_101112_202122);
            end
            step(1'b1, sof_first && (k == k_from), 1'b1, 1'b0, pv(k / W, k % W));
        end
    endtask

    logic [71:0] ref_q [$];
    int          first_k;

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("reset_window", obs, 72'h0);
        chk("reset_flags", {70'd0, win_valid, frame_done}, 72'h0);
        chk_on = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Full-rate frame
        obs_q.delete(); done_cnt = 0;
        send_range(0, W * H - 1, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("t1_count", 72'(obs_q.size()), 72'd4);
        if (obs_q.size() == 4) begin
            chk("t1_first", obs_q[0], 72'h000102_101112_202122);
            chk("t1_last", obs_q[3], 72'h111213_212223_313233);
        end
        chk("t1_done", 72'(done_cnt), 72'd1);
        ref_q = obs_q;

        // Gaps and a 3-cycle act drop in row 2
        obs_q.delete(); done_cnt = 0;
        send_range(0, W * H - 1, 1'b1, 1'b1, 1'b1);
        idle(2);
        chk("t2_count", 72'(obs_q.size()), 72'd4);
        if (obs_q.size() == 4 && ref_q.size() == 4)
            for (int i = 0; i < 4; i++)
                chk("t2_seq", obs_q[i], ref_q[i]);
        chk("t2_done", 72'(done_cnt), 72'd1);

        // Two back-to-back frames, only the first marked with pix_sof
        obs_q.delete(); done_cnt = 0;
        send_range(0, W * H - 1, 1'b1, 1'b0, 1'b0);
        send_range(0, W * H - 1, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("t3_count", 72'(obs_q.size()), 72'd8);
        if (obs_q.size() == 8 && ref_q.size() == 4)
            for (int i = 0; i < 8; i++)
                chk("t3_seq", obs_q[i], ref_q[i % 4]);
        chk("t3_done", 72'(done_cnt), 72'd2);

        // Reset mid-frame after pixel (2,3); the pixel presented with rst is dropped
        send_range(0, 2 * W + 3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, pv(3, 0));
        chk("t4_rst_window", obs, 72'h0);
        chk("t4_rst_flags", {70'd0, win_valid, frame_done}, 72'h0);
        obs_q.delete(); done_cnt = 0;
        first_k = -1;
        for (int k = 0; k < W * H; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, pv(k / W, k % W));
            if (win_valid && first_k < 0)
                first_k = k;
        end
        idle(2);
        chk("t4_first_k", 72'(first_k), 72'd10);
        chk("t4_count", 72'(obs_q.size()), 72'd4);
        chk("t4_done", 72'(done_cnt), 72'd1);

        // pix_sof mid-frame at original (1,2)
        obs_q.delete(); done_cnt = 0;
        send_range(0, W + 1, 1'b1, 1'b0, 1'b0);
        send_range(0, W * H - 1, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("t5_count", 72'(obs_q.size()), 72'd4);
        if (obs_q.size() == 4 && ref_q.size() == 4)
            for (int i = 0; i < 4; i++)
                chk("t5_seq", obs_q[i], ref_q[i]);
        chk("t5_done", 72'(done_cnt), 72'd1);

        // Stall on the final pixel
        obs_q.delete(); done_cnt = 0;
        send_range(0, W * H - 2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, pv(3, 3));
        chk("t6_stall_flags", {70'd0, win_valid, frame_done}, 72'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, pv(3, 3));
        chk("t6_accept_flags", {70'd0, win_valid, frame_done}, 72'h3);
        chk("t6_last", obs, 72'h111213_212223_313233);
        idle(2);
        chk("t6_done", 72'(done_cnt), 72'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
